jpeg_bitstream_writer: RTL and testbench

JPEG_BITSTREAM_WRITER -- requirements
Module: jpeg_bitstream_writer

---
 rtl/jpeg_bitstream_writer.sv | 144 ++++++++++++++
 tb/tb_jpeg_bitstream_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_writer.sv
// JPEG entropy-coded segment writer: packs variable-length codes MSB-first into
// bytes, inserts a 0x00 after every 0xFF, and pads with 1-bits on flush.
module jpeg_bitstream_writer #(
  parameter int CODE_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic [5:0]        code_len,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              flush,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              flush_done,
  output logic [31:0]       byte_count,
  output logic [1:0]        dbg_state
);

  // Handshakes: a code moves when code_valid && code_ready; a byte moves when
  // byte_valid && byte_ready. A held byte never changes until it moves.

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STUFF = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [6:0] CODE_W7 = 7'(CODE_W);
  localparam logic [6:0] ACC_W7  = 7'(ACC_W);
  localparam logic [ACC_W-1:0] TOP8 = {8'hFF, {(ACC_W-8){1'b0}}};

  state_t           state_q, state_d, ret_q, ret_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [6:0]       fill_q, fill_d;
  logic [7:0]       byte_q, byte_d;
  logic             bv_q, bv_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [6:0]       len_eff, shamt;
  logic [ACC_W-1:0] code_ext, pad_mask;
  logic             byte_done, stuff_pend, can_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      byte_q  <= 8'h00;
      bv_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      byte_q  <= byte_d;
      bv_q    <= bv_d;
      cnt_q   <= cnt_d;
    end
  end

  // New bits land directly below the fill bits of the MSB-aligned accumulator.
  assign len_eff  = ({1'b0, code_len} > CODE_W7) ? CODE_W7 : {1'b0, code_len};
  assign code_ext = {{(ACC_W-CODE_W){1'b0}}, code_in} & ~({ACC_W{1'b1}} << len_eff);
  assign shamt    = ACC_W7 - fill_q - len_eff;
  assign pad_mask = ({ACC_W{1'b1}} >> fill_q) & TOP8;

  assign byte_done  = bv_q && byte_ready;
  // A held 0xFF blocks new input so the stuff byte cannot race a code or flush.
  assign stuff_pend = bv_q && (byte_q == 8'hFF);
  assign can_load   = (fill_q >= 7'd8) && (!bv_q || byte_done);
  assign code_ready = (state_q == ST_RUN) && (fill_q < 7'd8) && !stuff_pend;

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    byte_d  = byte_q;
    bv_d    = bv_q;
    cnt_d   = cnt_q;
    if (byte_done) begin
      cnt_d = cnt_q + 32'd1;
      bv_d  = 1'b0;
    end
    case (state_q)
      ST_RUN, ST_FLUSH: begin
        if (byte_done && byte_q == 8'hFF) begin
          state_d = ST_STUFF;
          ret_d   = state_q;
          byte_d  = 8'h00;
          bv_d    = 1'b1;
        end else if (can_load) begin
          byte_d = acc_q[ACC_W-1 -: 8];
          bv_d   = 1'b1;
          acc_d  = acc_q << 8;
          fill_d = fill_q - 7'd8;
        end
        if (state_q == ST_RUN) begin
          if (code_valid && code_ready) begin
            acc_d  = acc_q | (code_ext << shamt);
            fill_d = fill_q + len_eff;
          end else if (flush && code_ready) begin
            state_d = ST_FLUSH;
            if (fill_q != 7'd0) begin
              acc_d  = acc_q | pad_mask;
              fill_d = 7'd8;
            end
          end
        end else if (fill_q == 7'd0 && !bv_q) begin
          state_d = ST_DONE;
        end
      end
      ST_STUFF: begin
        if (byte_done) begin
          state_d = ret_q;
          if (fill_q >= 7'd8) begin
            byte_d = acc_q[ACC_W-1 -: 8];
            bv_d   = 1'b1;
            acc_d  = acc_q << 8;
            fill_d = fill_q - 7'd8;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        acc_d   = '0;
        fill_d  = '0;
      end
    endcase
  end

  assign byte_out   = byte_q;
  assign byte_valid = bv_q;
  assign byte_count = cnt_q;
  assign flush_done = (state_q == ST_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jpeg_bitstream_writer.sv
// Bench for jpeg_bitstream_writer: directed table, hand-written corner cases,
// and random codes scored against a bit-queue model of the output stream.
module tb_jpeg_bitstream_writer;

  logic        clk, rst;
  logic [31:0] code_in;
  logic [5:0]  code_len;
  logic        code_valid, code_ready, flush;
  logic [7:0]  byte_out;
  logic        byte_valid, byte_ready, flush_done;
  logic [31:0] byte_count;
  logic [1:0]  dbg_state;

  jpeg_bitstream_writer dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_len(code_len),
    .code_valid(code_valid), .code_ready(code_ready), .flush(flush),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .flush_done(flush_done), .byte_count(byte_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; code_valid = 1'b0; flush = 1'b0; code_in = '0; code_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic       bq[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int  hs_cnt = 0, exp_flush = 0, got_flush = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_b;

  task automatic model_drain();
    logic [7:0] b;
    while (bq.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bq.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bq.delete(); exp_q.delete(); hold_v = 1'b0; hs_cnt = 0;
    end else begin
      if (hold_v) begin
        chk("hold_valid", {31'd0, byte_valid}, 32'd1);
        chk("hold_byte", {24'd0, byte_out}, {24'd0, hold_b});
      end
      hold_v = byte_valid && !byte_ready;
      hold_b = byte_out;
      if (byte_valid && byte_ready) begin
        got_q.push_back(byte_out);
        hs_cnt++;
        if (exp_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL stream: got %02h expected no byte", byte_out);
        end else begin
          chk("stream", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
        end
      end
      if (code_valid && code_ready) begin
        for (int i = ((code_len > 6'd32) ? 32 : int'(code_len)) - 1; i >= 0; i--)
          bq.push_back(code_in[i]);
      end else if (flush && code_ready) begin
        while (bq.size() % 8 != 0) bq.push_back(1'b1);
        exp_flush++;
      end
      model_drain();
      if (flush_done) got_flush++;
    end
  end

  // ---------------- drivers ----------------
  int acc_cyc, done_cyc;
  logic rand_rdy = 1'b0;

  always @(posedge clk) if (rand_rdy) begin
    #1 byte_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send_code(input logic [31:0] c, input logic [5:0] l);
    bit ok = 0;
    code_in = c; code_len = l; code_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (code_ready) ok = 1;
    end
    @(posedge clk); #1 code_valid = 1'b0;
    if (!ok) begin
      vec_cnt++; err_cnt++;
      $display("FAIL code_accept: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic send_flush();
    bit ok = 0;
    flush = 1'b1; code_valid = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (code_ready) begin ok = 1; acc_cyc = cyc; end
    end
    @(posedge clk); #1 flush = 1'b0;
    if (!ok) begin
      vec_cnt++; err_cnt++;
      $display("FAIL flush_accept: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (flush_done) begin ok = 1; done_cyc = cyc; end
    end
    @(posedge clk); #1;
    if (!ok) begin
      vec_cnt++; err_cnt++;
      $display("FAIL flush_done: got no pulse expected pulse within 300 cycles");
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0]      code;
    logic [5:0]       len;
    int               nbytes;
    logic [0:3][7:0]  b;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'h0000_00AB, 6'd8,  1, {8'hAB, 8'h00, 8'h00, 8'h00}};
    tbl[1] = '{32'h0000_0005, 6'd3,  1, {8'hBF, 8'h00, 8'h00, 8'h00}};
    tbl[2] = '{32'h0000_FFFF, 6'd16, 4, {8'hFF, 8'h00, 8'hFF, 8'h00}};
    tbl[3] = '{32'h1234_5678, 6'd63, 4, {8'h12, 8'h34, 8'h56, 8'h78}};
    tbl[4] = '{32'hFFFF_FFFF, 6'd0,  0, {8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[5] = '{32'h0000_03F0, 6'd4,  1, {8'h0F, 8'h00, 8'h00, 8'h00}};
    tbl[6] = '{32'h0000_01FE, 6'd9,  3, {8'hFF, 8'h00, 8'h7F, 8'h00}};

    byte_ready = 1'b1;
    do_reset();

    // reset then idle
    repeat (3) @(negedge clk);
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_byte_count", byte_count, 32'd0);
    chk("rst_code_ready", {31'd0, code_ready}, 32'd1);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      got_q.delete(); got_flush = 0;
      send_code(tbl[v].code, tbl[v].len);
      send_flush();
      wait_done();
      chk("tbl_nbytes", got_q.size(), tbl[v].nbytes);
      for (int i = 0; i < tbl[v].nbytes && i < got_q.size(); i++)
        chk("tbl_byte", {24'd0, got_q[i]}, {24'd0, tbl[v].b[i]});
      chk("tbl_byte_count", byte_count, tbl[v].nbytes);
      chk("tbl_flush_pulses", got_flush, 32'd1);
    end

    // flush with nothing buffered: no bytes, pulse two cycles after request
    do_reset();
    got_q.delete(); got_flush = 0;
    send_flush();
    wait_done();
    chk("empty_flush_latency", done_cyc - acc_cyc, 32'd2);
    chk("empty_flush_bytes", got_q.size(), 32'd0);
    chk("empty_flush_pulses", got_flush, 32'd1);

    // back-pressure: 0x12 must be held, input stalled, then 0x12 0x34
    do_reset();
    got_q.delete();
    byte_ready = 1'b0;
    send_code(32'h123, 6'd12);
    send_code(32'h4, 6'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, byte_valid}, 32'd1);
      chk("bp_byte", {24'd0, byte_out}, 32'h12);
      chk("bp_code_ready", {31'd0, code_ready}, 32'd0);
    end
    @(posedge clk); #1 byte_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("bp_nbytes", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("bp_first", {24'd0, got_q[0]}, 32'h12);
      chk("bp_second", {24'd0, got_q[1]}, 32'h34);
    end
    chk("bp_byte_count", byte_count, 32'd2);

    // reset while the stuff byte is held: it must vanish
    do_reset();
    got_q.delete();
    byte_ready = 1'b0;
    send_code(32'hFF, 6'd8);
    repeat (3) @(posedge clk); #1 byte_ready = 1'b1;
    @(posedge clk); #1 byte_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("mid_rst_byte", {24'd0, byte_out}, 32'd0);
    chk("mid_rst_count", byte_count, 32'd0);
    chk("mid_rst_code_ready", {31'd0, code_ready}, 32'd1);
    chk("mid_rst_flush_done", {31'd0, flush_done}, 32'd0);
    @(posedge clk); #1 byte_ready = 1'b1;
    send_code(32'h01, 6'd8);
    repeat (4) @(posedge clk); #1;
    chk("mid_rst_nbytes", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("mid_rst_pre", {24'd0, got_q[0]}, 32'hFF);
      chk("mid_rst_post", {24'd0, got_q[1]}, 32'h01);
    end

    // random codes, random back-pressure, occasional flushes
    do_reset();
    exp_flush = 0; got_flush = 0;
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        send_flush();
        wait_done();
      end else begin
        send_code($urandom, ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 32)));
      end
    end
    send_flush();
    wait_done();
    rand_rdy = 1'b0;
    @(posedge clk); #2 byte_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("rand_leftover", exp_q.size(), 32'd0);
    chk("rand_flush_pulses", got_flush, exp_flush);
    chk("rand_byte_count", byte_count, hs_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
